// File: rtl/rv32i_dmem_arbiter.sv
// Two-port (core / debug) data-memory arbiter for an RV32I core.
// One transaction every three cycles: IDLE samples and latches the winner,
// ACCESS drives the memory strobe, RESP returns aligned read data or error.
module rv32i_dmem_arbiter #(
   parameter int unsigned N            = 32,
   parameter int unsigned DMEM_BYTES   = 256,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_c_req,
   input  logic         i_c_we,
   input  logic [1:0]   i_c_size,
   input  logic [N-1:0] i_c_addr,
   input  logic [N-1:0] i_c_wdata,
   output logic         o_c_gnt,
   output logic         o_c_done,
   input  logic         i_d_req,
   input  logic         i_d_we,
   input  logic [1:0]   i_d_size,
   input  logic [N-1:0] i_d_addr,
   input  logic [N-1:0] i_d_wdata,
   output logic         o_d_gnt,
   output logic         o_d_done,
   output logic [N-1:0] o_rdata,
   output logic         o_err,
   output logic         o_mem_en,
   output logic         o_mem_we,
   output logic [3:0]   o_mem_be,
   output logic [N-1:0] o_mem_addr,
   output logic [N-1:0] o_mem_wdata,
   input  logic [N-1:0] i_mem_rdata
);

   localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
   localparam logic [N:0] DmemLimit = (N+1)'(DMEM_BYTES);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic            r_owner;    // 0 core, 1 debug
   logic            r_we;
   logic [1:0]      r_size;
   logic [1:0]      r_addr_lo;
   logic            r_err;
   logic            r_c_gnt, r_d_gnt, r_c_done, r_d_done;
   logic            r_mem_en, r_mem_we;
   logic [3:0]      r_mem_be;
   logic [N-1:0]    r_mem_addr, r_mem_wdata;

   logic            w_any_req, w_d_win;
   logic            w_we, w_err;
   logic [1:0]      w_size;
   logic [N-1:0]    w_addr, w_wdata, w_wdata_rep;
   logic [3:0]      w_be;
   logic [N-1:0]    w_shift, w_rdata;

   // Pick the winner and pre-decode its command (error, lanes, store data).
   always_comb begin
      w_any_req = i_c_req | i_d_req;
      // Debug only overtakes a pending core request once the core has starved it.
      w_d_win   = i_d_req & (~i_c_req | (r_cnt == CntMax));
      w_we      = w_d_win ? i_d_we    : i_c_we;
      w_size    = w_d_win ? i_d_size  : i_c_size;
      w_addr    = w_d_win ? i_d_addr  : i_c_addr;
      w_wdata   = w_d_win ? i_d_wdata : i_c_wdata;

      w_err = ({1'b0, w_addr} >= DmemLimit)
            | (w_size == 2'b11)
            | ((w_size == 2'b01) & w_addr[0])
            | ((w_size == 2'b10) & (w_addr[1:0] != 2'b00));

      w_be        = 4'b0000;
      w_wdata_rep = w_wdata;
      case (w_size)
         2'b00: begin
            w_be        = 4'b0001 << w_addr[1:0];
            w_wdata_rep = {(N/8){w_wdata[7:0]}};
         end
         2'b01: begin
            w_be        = 4'b0011 << w_addr[1:0];
            w_wdata_rep = {(N/16){w_wdata[15:0]}};
         end
         2'b10: w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // Arbitration FSM with registered grant/done pulses and memory command.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_size      <= 2'b00;
         r_addr_lo   <= 2'b00;
         r_err       <= 1'b0;
         r_c_gnt     <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_c_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'b0000;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_c_gnt     <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_c_done    <= 1'b0;
         r_d_done    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= 4'b0000;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         unique case (r_state)
            StIdle: begin
               if (!i_d_req || w_d_win) begin
                  r_cnt <= '0;
               end else if (r_cnt != CntMax) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               if (w_any_req) begin
                  r_state   <= StAccess;
                  r_owner   <= w_d_win;
                  r_we      <= w_we;
                  r_size    <= w_size;
                  r_addr_lo <= w_addr[1:0];
                  r_err     <= w_err;
                  r_c_gnt   <= ~w_d_win;
                  r_d_gnt   <= w_d_win;
                  // A faulting command is granted but never reaches memory.
                  if (!w_err) begin
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= w_we;
                     r_mem_be    <= w_be;
                     r_mem_addr  <= {w_addr[N-1:2], 2'b00};
                     r_mem_wdata <= w_wdata_rep;
                  end
               end
            end
            StAccess: begin
               r_state  <= StResp;
               r_c_done <= ~r_owner;
               r_d_done <= r_owner;
            end
            StResp: r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   // Memory data arrives during RESP, so read alignment is combinational there.
   always_comb begin
      w_shift = i_mem_rdata >> {r_addr_lo, 3'b000};
      w_rdata = '0;
      if ((r_state == StResp) && !r_we && !r_err) begin
         case (r_size)
            2'b00:   w_rdata = {{(N-8){1'b0}}, w_shift[7:0]};
            2'b01:   w_rdata = {{(N-16){1'b0}}, w_shift[15:0]};
            2'b10:   w_rdata = w_shift;
            default: w_rdata = '0;
         endcase
      end
   end

   assign o_c_gnt     = r_c_gnt;
   assign o_d_gnt     = r_d_gnt;
   assign o_c_done    = r_c_done;
   assign o_d_done    = r_d_done;
   assign o_rdata     = w_rdata;
   assign o_err       = (r_state == StResp) & r_err;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_be    = r_mem_be;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/rv32i_dmem_arbiter.md
RV32I_DMEM_ARBITER -- requirements
Module: rv32i_dmem_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, data/address width.
REQ-002 SHALL have parameter DMEM_BYTES, default 256, data memory size in bytes; legal addresses are 0..DMEM_BYTES-1.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive core wins allowed while debug waits.
REQ-004 SHALL have port i_clk  in  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_c_req  in  1  core (MEM stage) access request, held until o_c_gnt.
REQ-007 SHALL have port i_c_we  in  1  core write (1) / read (0).
REQ-008 SHALL have port i_c_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 SHALL have port i_c_addr  in  N  core byte address.
REQ-010 SHALL have port i_c_wdata  in  N  core store data, right-aligned.
REQ-011 SHALL have port o_c_gnt  out  1  one-cycle pulse: core command accepted.
REQ-012 SHALL have port o_c_done  out  1  one-cycle pulse: core transaction complete.
REQ-013 SHALL have ports i_d_req, i_d_we, i_d_size, i_d_addr, i_d_wdata, o_d_gnt, o_d_done: the debug/loader port, with widths and meanings identical to REQ-006..012.
REQ-014 SHALL have port o_rdata  out  N  read data: right-aligned and zero-extended, valid with done.
REQ-015 SHALL have port o_err  out  1  error flag, valid with done.
REQ-016 SHALL have port o_mem_en  out  1  memory access strobe.
REQ-017 SHALL have port o_mem_we  out  1  memory write enable, qualified by o_mem_en.
REQ-018 SHALL have port o_mem_be  out  4  byte-lane enables.
REQ-019 SHALL have port o_mem_addr  out  N  word-aligned address, addr & ~3.
REQ-020 SHALL have port o_mem_wdata  out  N  store data replicated to lanes: byte in all 4 lanes, half in both halves.
REQ-021 SHALL have port i_mem_rdata  in  N  memory read word, valid the cycle after o_mem_en.

Function
REQ-022 FSM SHALL have three states: IDLE, ACCESS and RESP. Transitions:
- IDLE to ACCESS when any request is sampled; the winner's command is latched at that edge.
- ACCESS to RESP unconditionally.
- RESP to IDLE unconditionally.
REQ-023 Timing SHALL be: request sampled at edge T; gnt high during cycle T+1 (ACCESS); done high during cycle T+2 (RESP). One transaction per 3 cycles; no pipelining.
REQ-024 Arbitration SHALL give the core priority when both requests are high, unless the starvation counter equals STARVE_LIMIT, in which case debug wins.
REQ-025 The starvation counter SHALL:
- increment on each core win while i_d_req=1;
- clear on a debug win, or when i_d_req is sampled 0 in IDLE;
- saturate at STARVE_LIMIT.
REQ-026 Requests SHALL be ignored in ACCESS and RESP. A requester whose req stays high is re-arbitrated in the next IDLE.
REQ-027 The error check SHALL flag, at latch time, any of: addr >= DMEM_BYTES; size==11; half with addr[0]=1; word with addr[1:0]!=0.
REQ-028 On an error, ACCESS SHALL keep o_mem_en=0 while gnt still pulses, and RESP SHALL assert done with o_err=1 and o_rdata=0.
REQ-029 o_mem_be SHALL be:
- byte: 0001 << addr[1:0];
- half: 0011 << addr[1:0];
- word: 1111.
REQ-030 o_mem_en, o_mem_we, o_mem_be, o_mem_addr and o_mem_wdata SHALL be driven from registers, and only in ACCESS; otherwise all are 0.
REQ-031 In RESP for a read, o_rdata SHALL be i_mem_rdata >> (8*addr[1:0]), masked to 8/16/32 bits. For a write, o_rdata SHALL be 0.
REQ-032 Only the owner's gnt/done SHALL pulse. o_c_gnt and o_d_gnt SHALL never both be high; likewise o_c_done and o_d_done.

Reset
REQ-033 While i_rst=1 at an edge, the block SHALL set: state IDLE, starvation counter 0, and every output 0. A transaction in flight is abandoned: no done is issued and no memory access occurs afterwards.
REQ-034 Requests SHALL be first sampled at the first edge with i_rst=0.

Verification
REQ-035 Core word read: addr 0x10, memory word 0xDEADBEEF -> gnt at T+1; mem_en=1, be=1111, addr 0x10; done at T+2 with rdata 0xDEADBEEF, err=0.
REQ-036 Core SB: data 0xA5 to addr 0x23 -> mem addr 0x20, be=1000, wdata 0xA5A5A5A5, mem_we=1; done, err=0.
REQ-037 Both requesters held high continuously -> grant order C,C,C,C,D,C,C,C,C,D; never two gnt in one cycle.
REQ-038 Debug LW at addr 0x102 (DMEM_BYTES=256) -> d_gnt pulses; mem_en stays 0; done with err=1, rdata=0.
REQ-039 Byte read at addr 0x06 of word 0x11223344 -> rdata 0x00000022.
REQ-040 i_rst=1 in the ACCESS cycle -> next cycle all outputs 0, no done; a new request after release completes normally.
